// File: rtl/alu_seq.sv
// Registered ALU: 16 logic functions, carry-chained arithmetic and an iterative
// shift-add unsigned multiplier, with valid/ready handshakes on both sides.
module alu_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             carry_in,
  input  logic             use_cflag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry_out,
  output logic             compare,
  output logic             zero,
  output logic             c_flag
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e            state_q, state_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              meq_q, meq_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              cout_q, cout_d;
  logic              cmp_q, cmp_d;
  logic              zero_q, zero_d;
  logic              cflag_q, cflag_d;
  logic              ov_q, ov_d;

  logic              cin;
  logic              accept;
  logic              is_mul;
  logic [WIDTH-1:0]  logic_res;
  logic [W1-1:0]     arith_sum;
  logic [W1-1:0]     ax, bx, cx;
  logic [W2-1:0]     prod_step;

  assign in_ready = ~rst & (state_q == ST_IDLE) & (~ov_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle datapath for the operands presented at the input
  always_comb begin
    cin    = use_cflag ? cflag_q : carry_in;
    is_mul = MUL_EN && !mode && (select == 4'h8);
    ax     = {1'b0, in_a};
    bx     = {1'b0, in_b};
    cx     = W1'(cin);
    logic_res = '0;
    unique case (select)
      4'h0: logic_res = ~in_a;
      4'h1: logic_res = ~(in_a | in_b);
      4'h2: logic_res = ~in_a & in_b;
      4'h3: logic_res = '0;
      4'h4: logic_res = ~(in_a & in_b);
      4'h5: logic_res = ~in_b;
      4'h6: logic_res = in_a ^ in_b;
      4'h7: logic_res = in_a & ~in_b;
      4'h8: logic_res = ~in_a | in_b;
      4'h9: logic_res = ~(in_a ^ in_b);
      4'hA: logic_res = in_b;
      4'hB: logic_res = in_a & in_b;
      4'hC: logic_res = '1;
      4'hD: logic_res = in_a | ~in_b;
      4'hE: logic_res = in_a | in_b;
      4'hF: logic_res = in_a;
      default: logic_res = '0;
    endcase
    arith_sum = '0;
    case (select)
      4'h0:    arith_sum = ax + cx;
      4'h1:    arith_sum = ax + bx + cx;
      4'h2:    arith_sum = ax + {1'b0, ~in_b} + cx;
      4'h3:    arith_sum = ax + {1'b0, {WIDTH{1'b1}}} + cx;
      4'h4:    arith_sum = ax + ax + cx;
      4'h5:    arith_sum = {1'b0, in_a | in_b} + cx;
      4'h6:    arith_sum = {1'b0, in_a & in_b} + cx;
      4'h7:    arith_sum = bx + cx;
      default: arith_sum = '0;
    endcase
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state: operation acceptance, multiply iteration and result load
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    meq_d    = meq_q;
    res_d    = res_q;
    hi_d     = hi_q;
    cout_d   = cout_q;
    cmp_d    = cmp_q;
    zero_d   = zero_q;
    cflag_d  = cflag_q;
    ov_d     = ov_q & ~out_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = ST_MUL;
            mcand_d  = {{WIDTH{1'b0}}, in_a};
            mplier_d = in_b;
            prod_d   = '0;
            cnt_d    = '0;
            meq_d    = (in_a == in_b);
          end else begin
            res_d   = mode ? logic_res : arith_sum[WIDTH-1:0];
            cout_d  = mode ? 1'b0 : arith_sum[WIDTH];
            hi_d    = '0;
            cmp_d   = (in_a == in_b);
            zero_d  = mode ? (logic_res == '0) : (arith_sum[WIDTH-1:0] == '0);
            cflag_d = mode ? 1'b0 : arith_sum[WIDTH];
            ov_d    = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = prod_step;
        cnt_d    = cnt_q + WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          res_d   = prod_step[WIDTH-1:0];
          hi_d    = prod_step[W2-1:WIDTH];
          cout_d  = 1'b0;
          cmp_d   = meq_q;
          zero_d  = (prod_step == '0);
          cflag_d = 1'b0;
          ov_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      meq_q    <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      cout_q   <= 1'b0;
      cmp_q    <= 1'b0;
      zero_q   <= 1'b0;
      cflag_q  <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      meq_q    <= meq_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      cout_q   <= cout_d;
      cmp_q    <= cmp_d;
      zero_q   <= zero_d;
      cflag_q  <= cflag_d;
      ov_q     <= ov_d;
    end
  end

  assign out_valid  = ov_q;
  assign alu_out    = res_q;
  assign alu_out_hi = hi_q;
  assign carry_out  = cout_q;
  assign compare    = cmp_q;
  assign zero       = zero_q;
  assign c_flag     = cflag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  select;
  logic        mode, carry_in, use_cflag;
  logic        out_valid, out_ready;
  logic [15:0] alu_out, alu_out_hi;
  logic        carry_out, compare, zero, c_flag;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .select(select), .mode(mode),
    .carry_in(carry_in), .use_cflag(use_cflag), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .carry_out(carry_out), .compare(compare), .zero(zero), .c_flag(c_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference functions straight from the operation tables
  function automatic logic [15:0] logic_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s);
    case (s)
      4'h0: return ~a;        4'h1: return ~(a | b);
      4'h2: return ~a & b;    4'h3: return 16'h0000;
      4'h4: return ~(a & b);  4'h5: return ~b;
      4'h6: return a ^ b;     4'h7: return a & ~b;
      4'h8: return ~a | b;    4'h9: return ~(a ^ b);
      4'hA: return b;         4'hB: return a & b;
      4'hC: return 16'hFFFF;  4'hD: return a | ~b;
      4'hE: return a | b;     default: return a;
    endcase
  endfunction

  function automatic logic [16:0] arith_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic c);
    int unsigned ua, ub, uc, r;
    ua = 32'(a); ub = 32'(b); uc = 32'(c);
    case (s)
      4'h0: r = ua + uc;
      4'h1: r = ua + ub + uc;
      4'h2: r = ua + (32'hFFFF - ub) + uc;
      4'h3: r = ua + 32'hFFFF + uc;
      4'h4: r = 2 * ua + uc;
      4'h5: r = 32'(a | b) + uc;
      4'h6: r = 32'(a & b) + uc;
      4'h7: r = ub + uc;
      default: r = 0;
    endcase
    return 17'(r);
  endfunction

  // Reference model state
  bit          m_valid = 0, m_cout = 0, m_cmp = 0, m_zero = 0, m_cflag = 0;
  logic [15:0] m_out = '0, m_hi = '0;
  bit          busy = 0;
  int          left = 0;
  logic [31:0] pend = '0;
  bit          pend_cmp = 0;

  always @(posedge clk or posedge rst) begin
    bit          rdy, ld, r_c, r_cmp, r_z, ci;
    logic [15:0] r_lo, r_hi;
    logic [16:0] s;
    if (rst) begin
      m_valid = 0; m_out = '0; m_hi = '0; m_cout = 0; m_cmp = 0;
      m_zero = 0; m_cflag = 0; busy = 0; left = 0;
    end else begin
      rdy = !busy && (!m_valid || out_ready);
      ld = 0; r_lo = '0; r_hi = '0; r_c = 0; r_cmp = 0; r_z = 0;
      if (busy) begin
        left--;
        if (left == 0) begin
          busy = 0; ld = 1;
          r_lo = pend[15:0]; r_hi = pend[31:16]; r_cmp = pend_cmp; r_z = (pend == 0);
        end
      end else if (in_valid && rdy) begin
        ci = use_cflag ? m_cflag : carry_in;
        if (!mode && select == 4'h8) begin
          busy = 1; left = 16;
          pend = 32'(in_a) * 32'(in_b);
          pend_cmp = (in_a == in_b);
        end else begin
          ld = 1; r_cmp = (in_a == in_b);
          if (mode) r_lo = logic_f(in_a, in_b, select);
          else begin
            s = arith_f(in_a, in_b, select, ci);
            r_lo = s[15:0]; r_c = s[16];
          end
          r_z = (r_lo == 0);
        end
      end
      if (ld) begin
        m_valid = 1; m_out = r_lo; m_hi = r_hi; m_cout = r_c;
        m_cmp = r_cmp; m_zero = r_z; m_cflag = r_c;
      end else if (m_valid && out_ready) m_valid = 0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    #2;
    chk("in_ready", 32'(in_ready), 32'(!rst && !busy && (!m_valid || out_ready)));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("c_flag", 32'(c_flag), 32'(m_cflag));
    if (m_valid || rst) begin
      chk("alu_out", 32'(alu_out), 32'(m_out));
      chk("alu_out_hi", 32'(alu_out_hi), 32'(m_hi));
      chk("carry_out", 32'(carry_out), 32'(m_cout));
      chk("compare", 32'(compare), 32'(m_cmp));
      chk("zero", 32'(zero), 32'(m_zero));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                      input logic md, input logic ci, input logic ucf);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; select = s; mode = md;
    carry_in = ci; use_cflag = ucf;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (!ok) chk("send_ready", 32'(in_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [15:0] lt [16];
  int t0;
  bit seen;

  initial begin
    lt[0] = 16'h0F0F; lt[1] = 16'h0303; lt[2] = 16'h0C0C; lt[3] = 16'h0000;
    lt[4] = 16'h3F3F; lt[5] = 16'h3333; lt[6] = 16'h3C3C; lt[7] = 16'h3030;
    lt[8] = 16'hCFCF; lt[9] = 16'hC3C3; lt[10] = 16'hCCCC; lt[11] = 16'hC0C0;
    lt[12] = 16'hFFFF; lt[13] = 16'hF3F3; lt[14] = 16'hFCFC; lt[15] = 16'hF0F0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; select = '0; mode = 1'b0;
    carry_in = 1'b0; use_cflag = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_out", 32'(alu_out), 32'd0);
    chk("rst_c_flag", 32'(c_flag), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Add chain with wrap-around and stored carry
    send(16'hFFFF, 16'h0001, 4'h1, 1'b0, 1'b0, 1'b0); #1;
    chk("add_latency", 32'(cyc - acc_cyc), 32'd1);
    chk("add_out", 32'(alu_out), 32'h0000);
    chk("add_carry", 32'(carry_out), 32'd1);
    chk("add_zero", 32'(zero), 32'd1);
    chk("add_cflag", 32'(c_flag), 32'd1);
    send(16'h0000, 16'h0000, 4'h1, 1'b0, 1'b0, 1'b1); #1;
    chk("chain_out", 32'(alu_out), 32'h0001);
    chk("chain_carry", 32'(carry_out), 32'd0);

    // Subtract
    send(16'h0005, 16'h0007, 4'h2, 1'b0, 1'b1, 1'b0); #1;
    chk("sub_out", 32'(alu_out), 32'hFFFE);
    chk("sub_carry", 32'(carry_out), 32'd0);
    send(16'h0007, 16'h0005, 4'h2, 1'b0, 1'b1, 1'b0); #1;
    chk("sub2_out", 32'(alu_out), 32'h0002);
    chk("sub2_carry", 32'(carry_out), 32'd1);

    // Logic sweep
    for (int s = 0; s < 16; s++) begin
      send(16'hF0F0, 16'hCCCC, 4'(s), 1'b1, 1'b1, 1'b0); #1;
      chk($sformatf("logic_%0d", s), 32'(alu_out), 32'(lt[s]));
      chk("logic_cmp", 32'(compare), 32'd0);
    end
    send(16'h1234, 16'h1234, 4'h6, 1'b1, 1'b0, 1'b0); #1;
    chk("eq_cmp", 32'(compare), 32'd1);
    chk("eq_zero", 32'(zero), 32'd1);

    // Reserved arithmetic code
    send(16'h0001, 16'h0002, 4'h9, 1'b0, 1'b1, 1'b0); #1;
    chk("rsv_out", 32'(alu_out), 32'h0000);
    chk("rsv_carry", 32'(carry_out), 32'd0);
    idle();

    // Full-width multiply
    send(16'hFFFF, 16'hFFFF, 4'h8, 1'b0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("mul_latency", 32'(cyc - acc_cyc), 32'd17);
    chk("mul_lo", 32'(alu_out), 32'h0001);
    chk("mul_hi", 32'(alu_out_hi), 32'hFFFE);
    chk("mul_carry", 32'(carry_out), 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply
    send(16'h00FF, 16'h0101, 4'h8, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    chk("rmul_out_valid", 32'(out_valid), 32'd0);
    chk("rmul_alu_out", 32'(alu_out), 32'd0);
    chk("rmul_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("rmul_no_result", 32'(seen), 32'd0);

    // Backpressure, take-and-accept, back-to-back
    send(16'h0003, 16'h0004, 4'h1, 1'b0, 1'b0, 1'b0); #1;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 16'd10; in_b = 16'd20; select = 4'h1; mode = 1'b0;
    carry_in = 1'b0; use_cflag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(alu_out), 32'h0007);
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_next", 32'(alu_out), 32'h001E);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    send(16'd0, 16'd100, 4'h1, 1'b0, 1'b0, 1'b0); #1;
    t0 = acc_cyc;
    chk("b2b_0", 32'(alu_out), 32'd100);
    for (int k = 1; k < 4; k++) begin
      send(16'(k), 16'd100, 4'h1, 1'b0, 1'b0, 1'b0); #1;
      chk("b2b_k", 32'(alu_out), 32'(100 + k));
    end
    chk("b2b_cycles", 32'(cyc - t0), 32'd4);
    idle();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Keeps the 16 logic functions and adds a defined arithmetic set.
- Adds a sticky carry flag for multi-word chaining and an iterative shift-add unsigned multiplier.
- Sits between the register file/operand latch and the writeback stage. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width (>=4).
- MUL_EN, 1, 1 = arithmetic select 4'b1000 is the multicycle multiply; 0 = that code is reserved.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  request accepted when in_valid & in_ready
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- select  input  4  function code
- mode  input  1  1 = logic, 0 = arithmetic
- carry_in  input  1  external carry
- use_cflag  input  1  1 = use stored c_flag as carry instead of carry_in
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result when out_valid & out_ready
- alu_out  output  WIDTH  result (product low word for MUL)
- alu_out_hi  output  WIDTH  product high word for MUL, else 0
- carry_out  output  1  carry of held result
- compare  output  1  (in_a == in_b) of the accepted operands
- zero  output  1  alu_out == 0
- c_flag  output  1  sticky carry register

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: out_valid, alu_out, alu_out_hi, carry_out, compare, zero, c_flag. in_ready=0 while rst is high. An in-flight multiply is discarded and no result is produced.
- in_ready = (state==IDLE) & (~out_valid | out_ready). A new operation can be accepted in the same cycle the held result is taken.
- cin = use_cflag ? c_flag : carry_in. It is sampled at acceptance.
- Logic, mode=1. carry_out=0.
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 all-zeros
  - 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B
  - 8 ~A|B; 9 ~(A^B); A B; B A&B
  - C all-ones; D A|~B; E A|B; F A
- Arithmetic, mode=0. Computed in WIDTH+1 bits; carry_out = bit WIDTH, alu_out = low WIDTH bits.
  - 0 A+cin; 1 A+B+cin; 2 A+~B+cin (subtract with cin=1, carry=1 means no borrow); 3 A+all-ones+cin
  - 4 A+A+cin; 5 (A|B)+cin; 6 (A&B)+cin; 7 B+cin
  - 8 MUL (MUL_EN=1); 9-F reserved
- Reserved codes: alu_out=0, carry_out=0, latency 1.
- Single-cycle ops: accepted at edge N, so out_valid=1 after edge N+1 with all result fields valid. Latency 1.
- MUL state machine: IDLE -> MUL on acceptance of mode=0, select=8.
  - Operands are latched; a WIDTH-bit counter runs one shift-add step per cycle for WIDTH cycles.
  - On the last step: MUL -> IDLE and the result is loaded.
  - out_valid rises WIDTH+1 cycles after acceptance.
  - {alu_out_hi, alu_out} = A*B unsigned. carry_out=0; cin is ignored.
- Output register holds all result fields stable while out_valid & ~out_ready. Operands may change freely after acceptance.
- On result load:
  - c_flag <= carry_out
  - zero <= (alu_out==0); for MUL, zero reflects the full 2*WIDTH product
  - compare <= operand equality
  - out_valid <= 1
- out_valid clears on out_ready when no new result loads in the same cycle.
- c_flag changes only on result load, never on handshake alone.
- Wrap-around: A=all-ones, B=1, cin=0, op 1 gives 0 with carry 1. No saturation.

Test Plan:
- Reset mid-MUL: accept MUL A=16'h00FF B=16'h0101, assert rst at cycle 5 -> all outputs 0 immediately, state IDLE, no out_valid afterwards.
- Add chain: op1 A=16'hFFFF B=16'h0001 cin=0 -> alu_out=0, carry_out=1, zero=1, c_flag=1. Next op1 A=0 B=0 use_cflag=1 -> alu_out=1, carry_out=0.
- Subtract: op2 A=16'h0005 B=16'h0007 cin=1 -> alu_out=16'hFFFE, carry_out=0. With A=7 B=5 -> alu_out=2, carry_out=1.
- Logic sweep: A=16'hF0F0 B=16'hCCCC over selects 0-F -> each value matches the table; carry_out=0; compare=0. With A=B -> compare=1.
- MUL: A=16'hFFFF B=16'hFFFF -> out_valid exactly 17 cycles after acceptance, alu_out_hi=16'hFFFE, alu_out=16'h0001. in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> result held stable and in_ready=0. Raise out_ready -> result is taken and the next op is accepted in the same cycle; back-to-back throughput of 1 per cycle with out_ready=1.
